countdown_timer: RTL

- Consumes the one-cycle-wide per-second tick from the design's one-second pulse generator.
- Holds a loadable MM:SS value as four BCD digits.
- Decrements the value on each accepted tick while running; on reaching 00:00 it emits a done pulse and holds an expired flag.
- Sits between the tick generator and the seven-segment display driver and buzzer logic.

---
 rtl/countdown_pkg.sv | 23 ++
 rtl/bcd_digit_down.sv | 32 +++
 rtl/countdown_timer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared types and helpers for the MM:SS countdown timer.
// State encodings, BCD digit limits and the load-time digit clamp.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_PAUSE   = 2'b10,
    ST_EXPIRED = 2'b11
  } state_t;

  localparam logic [3:0] BCD_MAX_ONES     = 4'd9;
  localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

  // Saturate an out-of-range digit to the largest legal value.
  function automatic logic [3:0] clamp_digit(
    input logic [3:0] d,
    input logic [3:0] max_val
  );
    return (d > max_val) ? max_val : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with load and borrow chaining.
// Ports: clk, rst, load, load_val, dec_en, borrow_in -> digit, borrow_out.
module bcd_digit_down #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic dec;

  assign dec        = dec_en & borrow_in;
  // Wrapping from 0 to MAX pulls a borrow from the next digit up.
  assign borrow_out = dec & (digit == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_val;
    end else if (dec) begin
      digit <= (digit == 4'd0) ? MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer driven by a per-second tick.
// Ports: clk, rst, tick, load/start/pause strobes, set_* digits in;
// cur_* digits, state, done pulse, expired level out (all registered).
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int TICKS_PER_STEP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] set_min_tens,
  input  logic [3:0] set_min_ones,
  input  logic [3:0] set_sec_tens,
  input  logic [3:0] set_sec_ones,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] cur_min_tens,
  output logic [3:0] cur_min_ones,
  output logic [3:0] cur_sec_tens,
  output logic [3:0] cur_sec_ones,
  output logic [1:0] state,
  output logic       done,
  output logic       expired
);

  localparam logic [7:0] PRE_LAST = 8'(TICKS_PER_STEP - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] pre_q;
  logic [7:0] pre_d;
  logic       load_acc;
  logic       step;
  logic       terminal;
  logic       is_zero;
  logic       is_one;

  logic       b_so;
  logic       b_st;
  logic       b_mo;
  logic       unused_borrow;

  assign is_zero = ({cur_min_tens, cur_min_ones,
                     cur_sec_tens, cur_sec_ones} == 16'h0000);
  assign is_one  = ({cur_min_tens, cur_min_ones,
                     cur_sec_tens, cur_sec_ones} == 16'h0001);

  // The step that leaves 00:01 is the one that lands on 00:00.
  assign terminal = step & is_one;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pre_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
    end
  end

  // Strobe priority load > start > pause; the first one legal
  // in the current state wins. Ticks only count in RUN when
  // no strobe was acted on (pause discards a coincident tick).
  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    load_acc = 1'b0;
    step     = 1'b0;
    if (load && state_q != ST_RUN) begin
      load_acc = 1'b1;
      state_d  = ST_IDLE;
      pre_d    = 8'd0;
    end else if (start && !is_zero &&
                 (state_q == ST_IDLE || state_q == ST_PAUSE)) begin
      state_d = ST_RUN;
      if (state_q == ST_IDLE) pre_d = 8'd0;
    end else if (pause && state_q == ST_RUN) begin
      state_d = ST_PAUSE;
    end else if (tick && state_q == ST_RUN) begin
      if (pre_q == PRE_LAST) begin
        pre_d = 8'd0;
        step  = 1'b1;
        if (is_one) state_d = ST_EXPIRED;
      end else begin
        pre_d = pre_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      done <= terminal;
      if (load_acc)      expired <= 1'b0;
      else if (terminal) expired <= 1'b1;
    end
  end

  assign state = state_q;

  bcd_digit_down #(.MAX(BCD_MAX_ONES)) u_sec_ones (
    .clk        (clk),
    .rst        (rst),
    .load       (load_acc),
    .load_val   (clamp_digit(set_sec_ones, BCD_MAX_ONES)),
    .dec_en     (step),
    .borrow_in  (1'b1),
    .digit      (cur_sec_ones),
    .borrow_out (b_so)
  );

  bcd_digit_down #(.MAX(BCD_MAX_SEC_TENS)) u_sec_tens (
    .clk        (clk),
    .rst        (rst),
    .load       (load_acc),
    .load_val   (clamp_digit(set_sec_tens, BCD_MAX_SEC_TENS)),
    .dec_en     (step),
    .borrow_in  (b_so),
    .digit      (cur_sec_tens),
    .borrow_out (b_st)
  );

  bcd_digit_down #(.MAX(BCD_MAX_ONES)) u_min_ones (
    .clk        (clk),
    .rst        (rst),
    .load       (load_acc),
    .load_val   (clamp_digit(set_min_ones, BCD_MAX_ONES)),
    .dec_en     (step),
    .borrow_in  (b_st),
    .digit      (cur_min_ones),
    .borrow_out (b_mo)
  );

  // 00:00 is never stepped, so the top digit never wraps.
  bcd_digit_down #(.MAX(BCD_MAX_ONES)) u_min_tens (
    .clk        (clk),
    .rst        (rst),
    .load       (load_acc),
    .load_val   (clamp_digit(set_min_tens, BCD_MAX_ONES)),
    .dec_en     (step),
    .borrow_in  (b_mo),
    .digit      (cur_min_tens),
    .borrow_out (unused_borrow)
  );

endmodule
